// File: rtl/alu_pkg.sv
// Shared FSM state type and RISC-V funct3/funct7 encodings for the alu_mc execute unit.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;
  localparam logic [6:0] FUNCT7_MEXT = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Whether rs1 / rs2 are treated as two's complement for a given M-ext op.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension datapath: shift-add multiply and restoring divide, one bit per cycle,
// operating on magnitudes with the sign applied on the final step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic            active_reg;
  logic            is_div_reg;
  logic [2:0]      op_reg;
  logic [CNT_W-1:0] cnt_reg;
  // mul: hi = partial product, lo = multiplier shifting out; div: hi = remainder, lo = dividend/quotient
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] m_reg;
  logic            neg_reg;
  logic            rneg_reg;
  logic            dz_reg;
  logic [XLEN-1:0] a_reg;

  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] hi_step;
  logic [XLEN-1:0] lo_step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign a_sgn = a[XLEN-1] && is_signed_a(op);
  assign b_sgn = b[XLEN-1] && is_signed_b(op);
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      is_div_reg <= 1'b0;
      op_reg     <= '0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      m_reg      <= '0;
      neg_reg    <= 1'b0;
      rneg_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      a_reg      <= '0;
    end else if (flush) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      is_div_reg <= op[2];
      op_reg     <= op;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= op[2] ? a_mag : b_mag;
      m_reg      <= op[2] ? b_mag : a_mag;
      neg_reg    <= op[2] ? ((op == F3_DIV) && (a_sgn ^ b_sgn)) : (a_sgn ^ b_sgn);
      rneg_reg   <= (op == F3_REM) && a_sgn;
      dz_reg     <= (b == '0);
      a_reg      <= a;
    end else if (active_reg) begin
      hi_reg  <= hi_step;
      lo_reg  <= lo_step;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) active_reg <= 1'b0;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_trial = div_shift - {1'b0, m_reg};
    if (is_div_reg) begin
      hi_step = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
      lo_step = {lo_reg[XLEN-2:0], ~div_trial[XLEN]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Result reflects the value the last step produces, so the top can latch it on that same edge.
  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = neg_reg ? -prod : prod;
    quo_fix  = neg_reg ? -lo_step : lo_step;
    rem_fix  = rneg_reg ? -hi_step : hi_step;
    if (!is_div_reg)
      result = (op_reg == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (dz_reg)
      result = op_reg[1] ? a_reg : '1;
    else
      result = op_reg[1] ? rem_fix : quo_fix;
  end

  assign done = active_reg && (cnt_reg == LAST);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32IM execute unit: handshake FSM, single-cycle base ops, iterative mul/div.
// Define ALU_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational one.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_t      state_reg;
  alu_state_t      state_next;
  logic [XLEN-1:0] result_reg;
  logic [XLEN-1:0] result_next;

  logic               accept;
  logic               is_mext;
  logic               is_alt;
  logic               base_ok;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sra_res;
  logic [XLEN-1:0]    base_result;
  logic               md_start;
  logic               md_done;
  logic [XLEN-1:0]    md_result;

  assign is_mext   = (funct7 == FUNCT7_MEXT);
  assign is_alt    = (funct7 == FUNCT7_ALT);
  assign base_ok   = (funct7 == FUNCT7_BASE) || (is_alt && (funct3 == F3_ADD || funct3 == F3_SR));
  assign in_ready  = !flush && ((state_reg == IDLE) || (state_reg == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == MUL) || (state_reg == DIV);
  assign result    = result_reg;
  assign shamt     = b[SHAMT_W-1:0];
  // Kept separate so the arithmetic shift is not turned unsigned by a surrounding expression.
  assign sra_res   = $signed(a) >>> shamt;

  always_comb begin
    base_result = '0;
    if (base_ok) begin
      case (funct3)
        F3_ADD:  base_result = is_alt ? (a - b) : (a + b);
        F3_SLL:  base_result = a << shamt;
        F3_SLT:  base_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        F3_SLTU: base_result = {{(XLEN-1){1'b0}}, (a < b)};
        F3_XOR:  base_result = a ^ b;
        F3_SR:   base_result = is_alt ? sra_res : (a >> shamt);
        F3_OR:   base_result = a | b;
        F3_AND:  base_result = a & b;
        default: base_result = '0;
      endcase
    end
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_result;

  // Sign-extended operands multiplied modulo 2^(2*XLEN) give the exact signed/unsigned product.
  assign fast_a      = {{XLEN{is_signed_a(funct3) & a[XLEN-1]}}, a};
  assign fast_b      = {{XLEN{is_signed_b(funct3) & b[XLEN-1]}}, b};
  assign fast_prod   = fast_a * fast_b;
  assign fast_result = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    md_start    = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (state_reg == DONE && out_ready) state_next = IDLE;
          if (accept) begin
            if (is_mext && funct3[2]) begin
              state_next = DIV;
              md_start   = 1'b1;
            end
`ifdef ALU_FAST_MUL_EN
            else if (is_mext) begin
              state_next  = DONE;
              result_next = fast_result;
            end
`else
            else if (is_mext) begin
              state_next = MUL;
              md_start   = 1'b1;
            end
`endif
            else begin
              state_next  = DONE;
              result_next = base_result;
            end
          end
        end
        MUL, DIV: begin
          if (md_done) begin
            state_next  = DONE;
            result_next = md_result;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (md_start),
    .op     (funct3),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total;
  int bad;

`ifdef ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  alu_mc #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [31:0] ref_alu(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] av, input logic [31:0] bv);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic            alt;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'd0, av};
    ub  = {32'd0, bv};
    alt = (f7 == 7'h20);
    if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb;          return p[31:0];  end
        3'd1: begin p = sa * sb;          return p[63:32]; end
        3'd2: begin p = sa * longint'(ub); return p[63:32]; end
        3'd3: begin p = ua * ub;          return p[63:32]; end
        3'd4: begin
          if (bv == 0) return 32'hFFFF_FFFF;
          p = sa / sb;
          return p[31:0];
        end
        3'd5: return (bv == 0) ? 32'hFFFF_FFFF : av / bv;
        3'd6: begin
          if (bv == 0) return av;
          p = sa % sb;
          return p[31:0];
        end
        default: return (bv == 0) ? av : av % bv;
      endcase
    end
    if (!(f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5)))) return 32'd0;
    case (f3)
      3'd0: return alt ? av - bv : av + bv;
      3'd1: return av << bv[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (av < bv) ? 32'd1 : 32'd0;
      3'd4: return av ^ bv;
      3'd5: begin
        p = sa >>> bv[4:0];
        return alt ? p[31:0] : av >> bv[4:0];
      end
      3'd6: return av | bv;
      default: return av & bv;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // One transaction: drive, accept, wait for result, optionally hold out_ready low.
  task automatic do_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] av, input logic [31:0] bv, input int hold);
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    exp     = ref_alu(f7, f3, av, bv);
    exp_lat = (f7 == 7'h01 && (f3[2] || !FAST)) ? 33 : 1;
    funct7 = f7; funct3 = f3; a = av; b = bv;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
    out_ready = (hold == 0);
    if (exp_lat > 1) chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold result"}, result, exp);
      chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    $display("txn %s f7=%02h f3=%0d a=%08h b=%08h -> %08h exp %08h lat=%0d hold=%0d",
             tag, f7, f3, av, bv, result, exp, lat, hold);
    out_ready = 1'b1;
  endtask

  logic [2:0]  t2_f3  [3] = '{3'd0, 3'd5, 3'd3};
  logic [6:0]  t2_f7  [3] = '{7'h20, 7'h20, 7'h00};
  logic [31:0] t2_a   [3] = '{32'd5, 32'h8000_0000, 32'd1};
  logic [31:0] t2_b   [3] = '{32'd7, 32'd4, 32'hFFFF_FFFF};
  logic [31:0] t2_exp [3] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1};

  initial begin
    int          seen;
    int          r;
    logic [6:0]  f7;
    total = 0; bad = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; funct3 = '0; funct7 = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset result", result, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);

    // Back-to-back base ops, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      funct7 = t2_f7[i]; funct3 = t2_f3[i]; a = t2_a[i]; b = t2_b[i]; in_valid = 1'b1;
      tick();
      chk("b2b valid", {31'd0, out_valid}, 32'd1);
      chk("b2b result", result, t2_exp[i]);
      $display("txn b2b%0d f7=%02h f3=%0d -> %08h exp %08h", i, t2_f7[i], t2_f3[i], result, t2_exp[i]);
    end
    in_valid = 1'b0;

    do_op("mulh", 7'h01, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mulh const", result, 32'h0000_0000);
    do_op("mulhu", 7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mulhu const", result, 32'hFFFF_FFFE);

    do_op("div", 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div const", result, 32'hFFFF_FFFD);
    do_op("rem", 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    chk("rem const", result, 32'hFFFF_FFFF);
    do_op("divu0", 7'h01, 3'd5, 32'd7, 32'd0, 0);
    chk("divu0 const", result, 32'hFFFF_FFFF);
    do_op("removf", 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("removf const", result, 32'h0000_0000);
    do_op("divovf", 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("divovf const", result, 32'h8000_0000);

    do_op("bp div", 7'h01, 3'd4, 32'd1000, 32'hFFFF_FFFD, 5);

    // Flush in the middle of a divide; an offer made during flush must be dropped.
    funct7 = 7'h01; funct3 = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1; in_valid = 1'b1; funct7 = 7'h01; funct3 = 3'd4; a = 32'd9; b = 32'd3;
    #1;
    chk("flush in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready after", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flush no ghost", 32'(seen), 32'd0);
    do_op("post flush add", 7'h00, 3'd0, 32'd2, 32'd3, 0);
    chk("post flush const", result, 32'd5);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      f7 = (r < 4) ? 7'h00 : (r < 6) ? 7'h20 : (r < 9) ? 7'h01 : 7'($urandom);
      do_op("rnd", f7, 3'($urandom), pick(), pick(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset while a divide is in flight.
    funct7 = 7'h01; funct3 = 3'd4; a = 32'd77; b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rerst busy", {31'd0, busy}, 32'd0);
    chk("rerst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rerst result", result, 32'd0);
    chk("rerst in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) tick();
    chk("rerst no ghost", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
